goomba_gravity_mover: RTL

Vertical motion stage for one Goomba. It drives `goomba_y`, which the Goomba left/right mover consumes, and it reads back that mover's `goomba_x`. Each movement tick it applies tile-quantised gravity against the level background: it falls with accelerating speed, snaps onto solid tiles and reports when it leaves the bottom of the screen.

---
 rtl/game_pkg.sv | 18 +
 rtl/goomba_gravity_mover_if.sv | 11 +
 rtl/goomba_tile_probe.sv | 24 ++
 rtl/goomba_gravity_mover.sv | 105 ++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: tile codes, FSM state type and geometry shared by the Goomba movers
package game_pkg;
   typedef enum logic [7:0] {BDR = 8'd0, SKY = 8'd1, BLK = 8'd2, GND = 8'd3} tile_t;
   typedef enum logic [1:0] {RESET, FALLING, GROUNDED, OFFSCREEN} state_t;
   localparam int CHARACTER_WIDTH = 42;
   localparam int SCREEN_HEIGHT   = 480;
   localparam int BLOCK_WIDTH     = 40;
   localparam int START_Y         = 100;
   localparam int MAX_FALL_SPEED  = 4;
   localparam int GRAVITY_DIV     = 8;
   localparam int RESPAWN_TICKS   = 120;
   localparam int ROWS            = 12;
   localparam int COLS            = 17;
   typedef logic [ROWS-1:0][COLS-1:0][7:0] tile_map_t;
   function automatic logic is_solid(input logic [7:0] t);
      return t == BLK || t == GND;
   endfunction
endpackage

// File: rtl/goomba_gravity_mover_if.sv
// goomba_gravity_mover_if: level map and x in, registered y/grounded/offscreen out
interface goomba_gravity_mover_if;
   import game_pkg::*;
   tile_map_t background;
   int        goomba_x;
   int        goomba_y;
   logic      grounded;
   logic      offscreen;
   modport master (output background, goomba_x, input goomba_y, grounded, offscreen);
   modport slave  (input background, goomba_x, output goomba_y, grounded, offscreen);
endinterface

// File: rtl/goomba_tile_probe.sv
// goomba_tile_probe: tile row of a probe y and whether either Goomba corner column is solid there
module goomba_tile_probe
   import game_pkg::*;
(
   input  int        x,
   input  int        py,
   input  tile_map_t background,
   output int        row,
   output logic      solid
);
   int         xr;
   logic [4:0] cl, cr;
   logic [7:0] tl, tr;
   // clamp both corner columns to the map and treat rows off the map as open sky
   always_comb begin
      xr    = x + CHARACTER_WIDTH - 1;
      cl    = x < 0 ? 5'd0 : x / BLOCK_WIDTH > COLS - 1 ? 5'(COLS - 1) : 5'(x / BLOCK_WIDTH);
      cr    = xr < 0 ? 5'd0 : xr / BLOCK_WIDTH > COLS - 1 ? 5'(COLS - 1) : 5'(xr / BLOCK_WIDTH);
      row   = py < 0 ? -1 : py / BLOCK_WIDTH;
      tl    = (row >= 0 && row < ROWS) ? background[row[3:0]][cl] : SKY;
      tr    = (row >= 0 && row < ROWS) ? background[row[3:0]][cr] : SKY;
      solid = is_solid(tl) || is_solid(tr);
   end
endmodule

// File: rtl/goomba_gravity_mover.sv
// goomba_gravity_mover: tile-quantised gravity for one Goomba; GOOMBA_RESPAWN_EN enables respawn after falling offscreen
module goomba_gravity_mover
   import game_pkg::*;
(
   input logic                   movement_clock,
   input logic                   reset,
   goomba_gravity_mover_if.slave bus
);
   localparam int GCW = $clog2(GRAVITY_DIV) + 1;
   state_t         state, state_n;
   int             y, y_n, y_f, g_row, f_row;
   logic [3:0]     v, v_n, v_sat;
   logic [GCW-1:0] gc, gc_n, gc_inc;
   logic           g_solid, f_solid;
`ifdef GOOMBA_RESPAWN_EN
   localparam int RCW = $clog2(RESPAWN_TICKS);
   logic [RCW-1:0] rc, rc_n;
`endif
   assign y_f          = y + int'(v);
   assign v_sat        = v < 4'(MAX_FALL_SPEED) ? v + 4'd1 : v;
   assign gc_inc       = gc + GCW'(1);
   assign bus.goomba_y = y;
   goomba_tile_probe u_support (
      .x(bus.goomba_x), .py(y + CHARACTER_WIDTH), .background(bus.background),
      .row(g_row), .solid(g_solid)
   );
   goomba_tile_probe u_fall (
      .x(bus.goomba_x), .py(y_f + CHARACTER_WIDTH - 1), .background(bus.background),
      .row(f_row), .solid(f_solid)
   );
   // next state, position, speed and gravity counter
   always_comb begin
      state_n = state;
      y_n     = y;
      v_n     = v;
      gc_n    = gc;
`ifdef GOOMBA_RESPAWN_EN
      rc_n    = rc;
`endif
      case (state)
         RESET: begin
            state_n = FALLING;
            v_n     = 4'd1;
            gc_n    = '0;
         end
         FALLING: begin
            gc_n = gc_inc == GCW'(GRAVITY_DIV) ? '0 : gc_inc;
            v_n  = gc_inc == GCW'(GRAVITY_DIV) ? v_sat : v;
            if (f_solid) begin
               state_n = GROUNDED;
               y_n     = f_row * BLOCK_WIDTH - CHARACTER_WIDTH;
               v_n     = '0;
            end else if (y_f >= SCREEN_HEIGHT) begin
               state_n = OFFSCREEN;
               y_n     = SCREEN_HEIGHT;
`ifdef GOOMBA_RESPAWN_EN
               rc_n    = '0;
`endif
            end else
               y_n = y_f;
         end
         GROUNDED: begin
            state_n = g_solid ? GROUNDED : FALLING;
            v_n     = g_solid ? 4'd0 : 4'd1;
            gc_n    = '0;
            // resting y was produced by a snap, so re-snapping to the support row holds it
            y_n     = g_solid ? g_row * BLOCK_WIDTH - CHARACTER_WIDTH : y;
         end
         default: begin
            y_n = SCREEN_HEIGHT;
`ifdef GOOMBA_RESPAWN_EN
            state_n = rc == RCW'(RESPAWN_TICKS - 1) ? RESET : OFFSCREEN;
            y_n     = rc == RCW'(RESPAWN_TICKS - 1) ? START_Y : SCREEN_HEIGHT;
            rc_n    = rc + RCW'(1);
            v_n     = '0;
            gc_n    = '0;
`endif
         end
      endcase
   end
   // state and registered outputs, cleared asynchronously
   always_ff @(posedge movement_clock or posedge reset) begin
      if (reset) begin
         state         <= RESET;
         y             <= START_Y;
         v             <= '0;
         gc            <= '0;
         bus.grounded  <= 1'b0;
         bus.offscreen <= 1'b0;
`ifdef GOOMBA_RESPAWN_EN
         rc            <= '0;
`endif
      end else begin
         state         <= state_n;
         y             <= y_n;
         v             <= v_n;
         gc            <= gc_n;
         bus.grounded  <= state_n == GROUNDED;
         bus.offscreen <= state_n == OFFSCREEN;
`ifdef GOOMBA_RESPAWN_EN
         rc            <= rc_n;
`endif
      end
   end
endmodule
